// File: rtl/dbus_axil_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_axil_bridge_pkg
// Description : Shared types and constants for the DBus to AXI4-Lite bridge.
//               Holds the bridge state encoding, the AXI response codes and
//               a strobe population-count helper used by the lane aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_axil_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } dbus_bridge_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Number of set bits in a 4-bit byte strobe (0..4).
    function automatic logic [2:0] strobe_popcount(input logic [3:0] strobe);
        return 3'(strobe[0]) + 3'(strobe[1]) + 3'(strobe[2]) + 3'(strobe[3]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_axil_bridge_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dbus_lane_align
// Description : Combinational byte-lane steering between the LSB-justified
//               DBus view and the word-aligned AXI view.
//   i_addr_lo      in   2   store byte offset (live request address)
//   i_st_data      in   32  store data, LSB-justified
//   i_st_strobe    in   4   store strobes, LSB-justified
//   i_ld_offset    in   2   load byte offset (captured at request)
//   i_ld_raw       in   32  raw AXI read word
//   o_st_data      out  32  store data shifted onto its byte lanes
//   o_st_strobe    out  4   strobes shifted onto their byte lanes
//   o_ld_data      out  32  load data with addressed byte in [7:0]
//   o_misaligned   out  1   store would spill past the word boundary
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_lane_align
    import dbus_axil_bridge_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_st_strobe,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strobe,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned
);

    assign o_st_data   = i_st_data << {i_addr_lo, 3'b000};
    assign o_st_strobe = i_st_strobe << i_addr_lo;
    assign o_ld_data   = i_ld_raw >> {i_ld_offset, 3'b000};

    // Offset plus access size beyond 4 bytes would cross into the next word.
    assign o_misaligned = ({2'b00, i_addr_lo} + {1'b0, strobe_popcount(i_st_strobe)}) > 4'd4;

endmodule
`default_nettype wire

// File: rtl/dbus_axil_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dbus_axil_bridge
// Description : Single-beat DBus (LSU side) to AXI4-Lite master bridge with
//               byte-lane alignment, error reporting and handshake timeout.
//   clk, rst_n                  clock, asynchronous active-low reset
//   dbus_rd_en/wr_en            load / store request (held while dbus_wait)
//   dbus_addr/wr_data/wr_strobe request address, store data and strobes
//   dbus_rd_data                load data, addressed byte in [7:0]
//   dbus_wait                   request in flight
//   dbus_err                    transaction aborted (valid in DONE cycle)
//   m_aw*/m_w*/m_b*             AXI4-Lite write channels
//   m_ar*/m_r*                  AXI4-Lite read channels
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_axil_bridge
    import dbus_axil_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbus_rd_en,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wr_data,
    input  logic [3:0]  dbus_wr_strobe,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_wait,
    output logic        dbus_err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam int unsigned      c_TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0]  c_TMAX = c_TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    dbus_bridge_state_t r_state, w_next;
    logic [c_TW-1:0]    r_timer;
    logic [31:0]        r_axi_addr, r_wdata, r_rd_data;
    logic [3:0]         r_wstrb;
    logic [1:0]         r_ld_off;
    logic               r_arvalid, r_awvalid, r_wvalid, r_err;

    logic [31:0]        w_st_data, w_ld_data;
    logic [3:0]         w_st_strobe;
    logic               w_misaligned, w_timeout, w_busy, w_aw_done, w_w_done;

    dbus_lane_align u_lane_align (
        .i_addr_lo    (dbus_addr[1:0]),
        .i_st_data    (dbus_wr_data),
        .i_st_strobe  (dbus_wr_strobe),
        .i_ld_offset  (r_ld_off),
        .i_ld_raw     (m_rdata),
        .o_st_data    (w_st_data),
        .o_st_strobe  (w_st_strobe),
        .o_ld_data    (w_ld_data),
        .o_misaligned (w_misaligned)
    );

    // The timer counts cycles spent in the current waiting state; it fires
    // in the TIMEOUT_CYCLES-th such cycle.
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout_en
            assign w_timeout = (r_timer == c_TMAX);
        end else begin : g_timeout_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_busy    = (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA) ||
                       (r_state == ST_WR_REQ)  || (r_state == ST_WR_RESP);
    // A write channel is finished once its valid is low or handshaking now.
    assign w_aw_done = !r_awvalid || m_awready;
    assign w_w_done  = !r_wvalid  || m_wready;

    // State and registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_axi_addr <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rd_data  <= '0;
            r_ld_off   <= '0;
            r_arvalid  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (w_busy) begin
                r_timer <= r_timer + c_TW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (dbus_rd_en && dbus_wr_en) begin
                        r_err <= 1'b1;
                    end else if (dbus_wr_en) begin
                        if (w_misaligned) begin
                            r_err <= 1'b1;
                        end else begin
                            r_axi_addr <= {dbus_addr[31:2], 2'b00};
                            r_wdata    <= w_st_data;
                            r_wstrb    <= w_st_strobe;
                            r_awvalid  <= 1'b1;
                            r_wvalid   <= 1'b1;
                        end
                    end else if (dbus_rd_en) begin
                        r_axi_addr <= {dbus_addr[31:2], 2'b00};
                        r_ld_off   <= dbus_addr[1:0];
                        r_arvalid  <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_arready || w_timeout) r_arvalid <= 1'b0;
                    if (!m_arready && w_timeout) r_err <= 1'b1;
                end
                ST_RD_DATA: begin
                    if (m_rvalid) begin
                        r_rd_data <= w_ld_data;
                        r_err     <= |m_rresp;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    if (m_awready || w_timeout) r_awvalid <= 1'b0;
                    if (m_wready  || w_timeout) r_wvalid  <= 1'b0;
                    if (!(w_aw_done && w_w_done) && w_timeout) r_err <= 1'b1;
                end
                ST_WR_RESP: begin
                    if (m_bvalid) begin
                        r_err <= |m_bresp;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dbus_rd_en && dbus_wr_en) w_next = ST_DONE;
                else if (dbus_wr_en)          w_next = w_misaligned ? ST_DONE : ST_WR_REQ;
                else if (dbus_rd_en)          w_next = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                if (m_arready)      w_next = ST_RD_DATA;
                else if (w_timeout) w_next = ST_DONE;
            end
            ST_RD_DATA: begin
                if (m_rvalid || w_timeout) w_next = ST_DONE;
            end
            ST_WR_REQ: begin
                if (w_aw_done && w_w_done) w_next = ST_WR_RESP;
                else if (w_timeout)        w_next = ST_DONE;
            end
            ST_WR_RESP: begin
                if (m_bvalid || w_timeout) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; readies are only ever raised in the
    // matching wait state, so late responses after a timeout are ignored.
    always_comb begin
        dbus_wait = (r_state != ST_DONE) && (dbus_rd_en || dbus_wr_en);
        m_rready  = (r_state == ST_RD_DATA);
        m_bready  = (r_state == ST_WR_RESP);
    end

    assign dbus_rd_data = r_rd_data;
    assign dbus_err     = r_err;
    assign m_araddr     = r_axi_addr;
    assign m_awaddr     = r_axi_addr;
    assign m_wdata      = r_wdata;
    assign m_wstrb      = r_wstrb;
    assign m_arvalid    = r_arvalid;
    assign m_awvalid    = r_awvalid;
    assign m_wvalid     = r_wvalid;

endmodule
`default_nettype wire
